// File: rtl/dht11_reader.sv
// dht11_reader
//   Runs one DHT11 single-wire transaction per start request: host start
//   pulse, sensor response, 40 data bits, checksum check. The last good
//   humidity/temperature reading is held on the data outputs for the
//   display stage. The sensor line is open-drain; this block only pulls it
//   low (dht_oe=1) or releases it (dht_oe=0).
//
// Ports
//   clk          system clock (CLK_HZ)
//   rst          synchronous, active-high reset
//   start        read request, sampled only while idle
//   dht_in       raw sensor line (asynchronous)
//   dht_oe       1 = pull line low, 0 = release
//   busy         transaction in progress
//   valid        one-cycle pulse, new reading latched
//   error        one-cycle pulse, timeout or checksum failure
//   hum_int, hum_dec, temp_int, temp_dec   last good reading
//   dbg_state_o  current FSM state encoding
//
// Handshake: start is a level sampled in IDLE only; there is no ready.
// valid/error are single-cycle pulses, mutually exclusive, and coincide
// with busy falling. Data outputs change only in the cycle valid is high.
module dht11_reader #(
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned START_LOW_US  = 18000,
  parameter int unsigned TIMEOUT_US    = 200,
  parameter int unsigned BIT_THRESH_US = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dht_in,
  output logic       dht_oe,
  output logic       busy,
  output logic       valid,
  output logic       error,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic [3:0] dbg_state_o
);

  localparam int unsigned TICK_DIV    = CLK_HZ / 1_000_000;
  localparam int unsigned PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [14:0] START_CNT   = 15'(START_LOW_US);
  localparam logic [14:0] TIMEOUT_CNT = 15'(TIMEOUT_US);
  localparam logic [15:0] THRESH_CNT  = 16'(BIT_THRESH_US);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_START_LOW = 4'd1,
    S_RELEASE   = 4'd2,
    S_RESP_LOW  = 4'd3,
    S_RESP_HIGH = 4'd4,
    S_BIT_LOW   = 4'd5,
    S_BIT_HIGH  = 4'd6,
    S_CHECK     = 4'd7
  } state_t;

  state_t        state_q;
  logic [2:0]    sync_q;
  logic          dly_q;
  logic [PW-1:0] presc_q;
  logic [14:0]   cnt_q;
  logic [5:0]    bits_q;
  logic [39:0]   shift_q;
  logic          oe_q, busy_q, valid_q, error_q;
  logic [7:0]    hum_int_q, hum_dec_q, temp_int_q, temp_dec_q;

  logic          line_w, rise_w, fall_w, us_tick;
  logic [15:0]   width_w;
  logic          bit_w;
  logic [7:0]    sum_w;
  logic          timeout_w;

  // Third synchronizer flop is the decoded line; dly_q is one cycle older.
  assign line_w = sync_q[2];
  assign rise_w = line_w & ~dly_q;
  assign fall_w = ~line_w & dly_q;

  assign us_tick = (presc_q == PRESC_MAX);

  // The falling edge arrives in the cycle that ends the high phase, so the
  // tick of that cycle is counted too. A high phase of exactly
  // BIT_THRESH_US ticks therefore reaches the threshold and decodes as 1.
  assign width_w = {1'b0, cnt_q} + {15'd0, us_tick};
  assign bit_w   = (width_w >= THRESH_CNT);

  // 8-bit sum, carries dropped.
  assign sum_w = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

  assign timeout_w = (cnt_q >= TIMEOUT_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 3'b111;
      dly_q   <= 1'b1;
      presc_q <= '0;
    end else begin
      sync_q  <= {sync_q[1:0], dht_in};
      dly_q   <= sync_q[2];
      presc_q <= us_tick ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bits_q     <= '0;
      shift_q    <= '0;
      oe_q       <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      hum_int_q  <= '0;
      hum_dec_q  <= '0;
      temp_int_q <= '0;
      temp_dec_q <= '0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      cnt_q   <= cnt_q + {14'd0, us_tick};
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (start) begin
            state_q <= S_START_LOW;
            busy_q  <= 1'b1;
            oe_q    <= 1'b1;
            bits_q  <= '0;
          end
        end
        S_START_LOW: begin
          if (cnt_q >= START_CNT) begin
            state_q <= S_RELEASE;
            cnt_q   <= '0;
            oe_q    <= 1'b0;
          end
        end
        S_RELEASE, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW: begin
          if ((state_q == S_RELEASE) && fall_w) begin
            state_q <= S_RESP_LOW;
            cnt_q   <= '0;
          end else if ((state_q == S_RESP_LOW) && rise_w) begin
            state_q <= S_RESP_HIGH;
            cnt_q   <= '0;
          end else if ((state_q == S_RESP_HIGH) && fall_w) begin
            state_q <= S_BIT_LOW;
            cnt_q   <= '0;
          end else if ((state_q == S_BIT_LOW) && rise_w) begin
            state_q <= S_BIT_HIGH;
            cnt_q   <= '0;
          end else if (timeout_w) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end
        end
        S_BIT_HIGH: begin
          if (fall_w) begin
            shift_q <= {shift_q[38:0], bit_w};
            bits_q  <= bits_q + 6'd1;
            cnt_q   <= '0;
            state_q <= (bits_q == 6'd39) ? S_CHECK : S_BIT_LOW;
          end else if (timeout_w) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end
        end
        S_CHECK: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          if (sum_w == shift_q[7:0]) begin
            valid_q    <= 1'b1;
            hum_int_q  <= shift_q[39:32];
            hum_dec_q  <= shift_q[31:24];
            temp_int_q <= shift_q[23:16];
            temp_dec_q <= shift_q[15:8];
          end else begin
            error_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          oe_q    <= 1'b0;
        end
      endcase
    end
  end

  assign dht_oe      = oe_q;
  assign busy        = busy_q;
  assign valid       = valid_q;
  assign error       = error_q;
  assign hum_int     = hum_int_q;
  assign hum_dec     = hum_dec_q;
  assign temp_int    = temp_int_q;
  assign temp_dec    = temp_dec_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dht11_reader.sv
// tb_dht11_reader
//   Directed bench for dht11_reader at 1 MHz (one us tick per clock).
//   A behavioural sensor drives the open-drain line; frames, checksum
//   failure, timeout, bit-width threshold, checksum wrap, start-while-busy
//   and mid-frame reset are exercised against hand-computed values.
module tb_dht11_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic       dht_in;
  logic       dht_oe;
  logic       busy;
  logic       valid;
  logic       error;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
  logic [3:0] dbg_state;
  logic       sens;

  int n_vec;
  int n_err;
  int v_cnt;
  int e_cnt;
  int both_cnt;

  // Open-drain line with pull-up: low if either side pulls it low.
  assign dht_in = dht_oe ? 1'b0 : sens;

  dht11_reader #(
    .CLK_HZ       (1_000_000),
    .START_LOW_US (20),
    .TIMEOUT_US   (200),
    .BIT_THRESH_US(40)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dht_in     (dht_in),
    .dht_oe     (dht_oe),
    .busy       (busy),
    .valid      (valid),
    .error      (error),
    .hum_int    (hum_int),
    .hum_dec    (hum_dec),
    .temp_int   (temp_int),
    .temp_dec   (temp_dec),
    .dbg_state_o(dbg_state)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Pulse monitor
  always @(negedge clk) begin
    if (valid) v_cnt++;
    if (error) e_cnt++;
    if (valid && error) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse start for one cycle, then count dht_oe high cycles until release.
  task automatic host_start(output int oe_len);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("oe_after_start", {31'd0, dht_oe}, 32'd1);
    oe_len = 1;
    while (dht_oe && oe_len < 100) begin
      @(negedge clk);
      if (dht_oe) oe_len++;
    end
  endtask

  // Full transaction with the sensor model. t40/t39 force a bit's high
  // width; start_at pulses start during that bit; rst_at resets there.
  task automatic run_frame(input logic [39:0] f, input int t40, input int t39,
                           input int start_at, input int rst_at);
    int oe_len;
    int hw;
    host_start(oe_len);
    check("start_low_len", {31'd0, (oe_len >= 20 && oe_len <= 22)}, 32'd1);
    repeat (20) @(negedge clk);
    sens = 1'b0;
    repeat (80) @(negedge clk);
    sens = 1'b1;
    repeat (80) @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      sens = 1'b0;
      if (i == rst_at) begin
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_oe", {31'd0, dht_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'h0);
        check("rst_state", {28'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        sens = 1'b1;
        repeat (10) @(negedge clk);
        return;
      end
      if (i == start_at) begin
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (48) @(negedge clk);
      end else begin
        repeat (50) @(negedge clk);
      end
      if (i == t40)      hw = 40;
      else if (i == t39) hw = 39;
      else               hw = f[39-i] ? 70 : 27;
      sens = 1'b1;
      repeat (hw) @(negedge clk);
    end
    sens = 1'b0;
    repeat (50) @(negedge clk);
    sens = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int v0;
    int e0;
    int oe_len;
    int k;
    n_vec = 0; n_err = 0; v_cnt = 0; e_cnt = 0; both_cnt = 0;
    rst = 1'b1; start = 1'b0; sens = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_oe", {31'd0, dht_oe}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_pulses", {30'd0, valid, error}, 32'd0);
    check("reset_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'h0);
    check("reset_state", {28'd0, dbg_state}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: good frame
    v0 = v_cnt; e0 = e_cnt;
    run_frame({8'h37, 8'h00, 8'h19, 8'h00, 8'h50}, -1, -1, -1, -1);
    check("s1_valid", v_cnt - v0, 32'd1);
    check("s1_error", e_cnt - e0, 32'd0);
    check("s1_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'h37001900);
    check("s1_busy", {31'd0, busy}, 32'd0);

    // 2: bad checksum keeps previous reading
    v0 = v_cnt; e0 = e_cnt;
    run_frame({8'h37, 8'h00, 8'h19, 8'h00, 8'h51}, -1, -1, -1, -1);
    check("s2_valid", v_cnt - v0, 32'd0);
    check("s2_error", e_cnt - e0, 32'd1);
    check("s2_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'h37001900);

    // 3: no sensor response -> timeout 200 ticks after release
    v0 = v_cnt; e0 = e_cnt;
    host_start(oe_len);
    check("s3_start_low_len", {31'd0, (oe_len >= 20 && oe_len <= 22)}, 32'd1);
    k = 0;
    while (!error && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("s3_timeout_cycles", {31'd0, (k >= 200 && k <= 201)}, 32'd1);
    check("s3_oe", {31'd0, dht_oe}, 32'd0);
    check("s3_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("s3_error", e_cnt - e0, 32'd1);
    check("s3_valid", v_cnt - v0, 32'd0);
    check("s3_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'h37001900);

    // 4: bit 16 high 40us -> 1, bit 17 high 39us -> 0
    v0 = v_cnt; e0 = e_cnt;
    run_frame({8'h00, 8'h00, 8'h80, 8'h00, 8'h80}, 16, 17, -1, -1);
    check("s4_valid", v_cnt - v0, 32'd1);
    check("s4_error", e_cnt - e0, 32'd0);
    check("s4_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'h00008000);

    // 5: checksum wraps (0xFF+0x01+0x02 = 0x102)
    v0 = v_cnt; e0 = e_cnt;
    run_frame({8'hFF, 8'h01, 8'h02, 8'h00, 8'h02}, -1, -1, -1, -1);
    check("s5_valid", v_cnt - v0, 32'd1);
    check("s5_error", e_cnt - e0, 32'd0);
    check("s5_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'hFF010200);

    // 6a: start during bit 10 is ignored
    v0 = v_cnt; e0 = e_cnt;
    run_frame({8'h37, 8'h00, 8'h19, 8'h00, 8'h50}, -1, -1, 10, -1);
    check("s6_valid", v_cnt - v0, 32'd1);
    check("s6_error", e_cnt - e0, 32'd0);
    check("s6_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'h37001900);

    // 6b: reset during bit 20 -> line released, data cleared, no pulses
    v0 = v_cnt; e0 = e_cnt;
    run_frame({8'hFF, 8'h01, 8'h02, 8'h00, 8'h02}, -1, -1, -1, 20);
    repeat (10) @(negedge clk);
    check("s6r_pulses", (v_cnt - v0) + (e_cnt - e0), 32'd0);
    check("s6r_busy", {31'd0, busy}, 32'd0);

    check("valid_error_overlap", both_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
